kbd_fifo_regs: RTL and testbench

- Consumes the 11-bit event word from the PS/2 keyboard decoder and buffers key events in a small FIFO.
- Exposes the FIFO to the 68000 as a 4-register memory-mapped peripheral, with DTACK generation and a level interrupt request.
- Sits between the ps2 module and the fx68k bus. The top level decodes the base address into cs and muxes dout into the CPU data-in path.

---
 rtl/kbd_pkg.sv | 43 ++++
 rtl/kbd_fifo_regs_if.sv | 47 ++++
 rtl/kbd_sync_fifo.sv | 79 +++++++
 rtl/kbd_fifo_regs.sv | 223 ++++++++++++++++++++++
 tb/tb_kbd_fifo_regs.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the PS/2 keyboard event FIFO peripheral:
//   - register offsets seen by the 68000 (CPU A[2:1])
//   - CTRL register bit positions
//   - key event word layout and width
//   - bus handshake state encoding
//   - count saturation helper used by the STATUS register
// -----------------------------------------------------------------------------
package kbd_pkg;

    // Register offsets within the peripheral window
    localparam logic [1:0] KBD_REG_DATA   = 2'd0;
    localparam logic [1:0] KBD_REG_STATUS = 2'd1;
    localparam logic [1:0] KBD_REG_CTRL   = 2'd2;

    // CTRL write bit positions
    localparam int KBD_CTRL_IRQ_EN  = 0;
    localparam int KBD_CTRL_FLUSH   = 1;
    localparam int KBD_CTRL_CLR_OVF = 2;

    // One buffered key event: {pressed, extended, code}
    localparam int KBD_EVT_W = 10;

    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } kbd_evt_t;

    // 68000 bus cycle tracking
    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_ACK  = 2'd2
    } kbd_bus_state_t;

    // STATUS only has a 4-bit count field; deeper FIFOs report 15 when fuller
    function automatic logic [3:0] kbd_sat4(input logic [31:0] n);
        return (n > 32'd15) ? 4'hF : n[3:0];
    endfunction

endpackage

// File: rtl/kbd_fifo_regs_if.sv
// -----------------------------------------------------------------------------
// kbd_fifo_regs_if
// 68000-side bus bundle for the keyboard FIFO peripheral.
//   cs        : address decode hit for this block's window
//   cpu_as_n  : address strobe, active low
//   cpu_rw    : 1 = read, 0 = write
//   cpu_a     : register offset (CPU A[2:1])
//   cpu_wdata : CPU write data
//   dout      : read data, held from access start until the next access
//   dtack_n   : data transfer acknowledge, active low
//   irq       : level interrupt request, active high
// Modports: master = CPU / bus side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface kbd_fifo_regs_if;

    logic        cs;
    logic        cpu_as_n;
    logic        cpu_rw;
    logic [1:0]  cpu_a;
    logic [15:0] cpu_wdata;
    logic [15:0] dout;
    logic        dtack_n;
    logic        irq;

    modport master (
        output cs,
        output cpu_as_n,
        output cpu_rw,
        output cpu_a,
        output cpu_wdata,
        input  dout,
        input  dtack_n,
        input  irq
    );

    modport slave (
        input  cs,
        input  cpu_as_n,
        input  cpu_rw,
        input  cpu_a,
        input  cpu_wdata,
        output dout,
        output dtack_n,
        output irq
    );

endinterface

// File: rtl/kbd_sync_fifo.sv
// -----------------------------------------------------------------------------
// kbd_sync_fifo
// Single-clock FIFO built from a plain register array (no block RAM).
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : write request and data; accepted when not full, or when a
//                pop in the same cycle frees a slot
//   pop        : read request; ignored when empty
//   flush      : empties the FIFO; wins over a concurrent push or pop
//   head       : oldest entry (valid when not empty)
//   full/empty : occupancy flags
//   count      : number of entries, AW+1 bits
// -----------------------------------------------------------------------------
module kbd_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the
    // power-of-two depth, and a push+pop pair leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // Storage array needs no reset; only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/kbd_fifo_regs.sv
// -----------------------------------------------------------------------------
// kbd_fifo_regs
// Buffers PS/2 key events in a small FIFO and exposes them to the 68000 as a
// four-register memory-mapped peripheral with DTACK generation and a level IRQ.
//
// Ports:
//   clk      : system (CPU domain) clock
//   reset    : asynchronous, active-high reset
//   ps2_key  : [10] toggles per event, [9] pressed, [8] extended, [7:0] code
//   bus      : kbd_fifo_regs_if.slave (cs, cpu_as_n, cpu_rw, cpu_a,
//              cpu_wdata, dout, dtack_n, irq)
//
// Registers (cpu_a):
//   0 DATA   R: {valid, 5'b0, pressed, extended, code}, pops when non-empty
//   1 STATUS R: {overflow, 11'b0, count[3:0]}
//   2 CTRL   R: {15'b0, irq_en}  W: bit0 irq_en, bit1 flush, bit2 clear overflow
//   3        R: 0
//
// Parameters:
//   FIFO_AW   : log2 of FIFO depth
//   DTACK_DLY : clocks from access start to dtack_n low (1..7)
//
// Build option:
//   KBD_TYPEMATIC_FILTER_EN : when defined, a held-key bitmap suppresses
//   auto-repeat make events for keys that are already down.
// -----------------------------------------------------------------------------
module kbd_fifo_regs
    import kbd_pkg::*;
#(
    parameter int FIFO_AW   = 3,
    parameter int DTACK_DLY = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [10:0]    ps2_key,
    kbd_fifo_regs_if.slave bus
);

    localparam logic [2:0] DLY_INIT = 3'(DTACK_DLY - 1);

    // Event capture
    logic [10:0]    key_q;
    logic           toggle_shadow;
    logic           primed;
    logic           evt_det;
    kbd_evt_t       evt;
    logic           push_req;

    // FIFO
    logic [KBD_EVT_W-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_AW:0]     fifo_count;
    logic                 fifo_pop;
    logic                 flush;

    // Bus side
    kbd_bus_state_t state;
    logic [2:0]     dly_cnt;
    logic           acc;
    logic           acc_q;
    logic           start;
    logic           ctrl_wr;
    logic [15:0]    rd_word;
    logic [15:0]    dout_q;
    logic           dtack_n_q;
    logic           irq_q;
    logic           irq_en;
    logic           overflow;
    logic           unused_wdata;

    assign unused_wdata = ^bus.cpu_wdata[15:3];

    // ps2_key is registered once; the toggle shadow is seeded from the live
    // input on the first clock after reset so no phantom event is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q         <= '0;
            toggle_shadow <= 1'b0;
            primed        <= 1'b0;
        end else begin
            key_q         <= ps2_key;
            toggle_shadow <= primed ? key_q[10] : ps2_key[10];
            primed        <= 1'b1;
        end
    end

    assign evt_det = primed & (key_q[10] ^ toggle_shadow);
    assign evt     = key_q[9:0];

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [511:0] held_map;
    logic         evt_repeat;

    assign evt_repeat = evt.pressed & held_map[{evt.extended, evt.code}];
    assign push_req   = evt_det & ~evt_repeat;

    // Track which keys are down so auto-repeat makes can be dropped; a
    // flush clears the map along with the FIFO contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_map <= '0;
        end else if (flush) begin
            held_map <= '0;
        end else if (evt_det) begin
            held_map[{evt.extended, evt.code}] <= evt.pressed;
        end
    end
`else
    assign push_req = evt_det;
`endif

    // Bus access qualification and the one-shot side effects of a new access
    assign acc      = bus.cs & ~bus.cpu_as_n;
    assign start    = acc & ~acc_q & (state == BUS_IDLE);
    assign fifo_pop = start & bus.cpu_rw & (bus.cpu_a == KBD_REG_DATA) & ~fifo_empty;
    assign ctrl_wr  = start & ~bus.cpu_rw & (bus.cpu_a == KBD_REG_CTRL);
    assign flush    = ctrl_wr & bus.cpu_wdata[KBD_CTRL_FLUSH];

    kbd_sync_fifo #(
        .WIDTH (KBD_EVT_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (evt),
        .pop   (fifo_pop),
        .flush (flush),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Read data for the register addressed at access start; writes latch 0
    always_comb begin
        rd_word = '0;
        if (bus.cpu_rw) begin
            case (bus.cpu_a)
                KBD_REG_DATA:   rd_word = fifo_empty ? 16'h0000
                                                     : {1'b1, 5'b0, fifo_head};
                KBD_REG_STATUS: rd_word = {overflow, 11'b0,
                                           kbd_sat4(32'(fifo_count))};
                KBD_REG_CTRL:   rd_word = {15'b0, irq_en};
                default:        rd_word = '0;
            endcase
        end
    end

    // Bus cycle FSM: latch read data at access start, count out the DTACK
    // delay, then hold dtack_n low until the strobe is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BUS_IDLE;
            dly_cnt   <= '0;
            dtack_n_q <= 1'b1;
            dout_q    <= '0;
            acc_q     <= 1'b0;
        end else begin
            acc_q <= acc;
            case (state)
                BUS_IDLE: begin
                    if (start) begin
                        dout_q  <= rd_word;
                        dly_cnt <= DLY_INIT;
                        state   <= BUS_WAIT;
                    end
                end
                BUS_WAIT: begin
                    if (bus.cpu_as_n) begin
                        state <= BUS_IDLE;
                    end else if (dly_cnt == 3'd0) begin
                        dtack_n_q <= 1'b0;
                        state     <= BUS_ACK;
                    end else begin
                        dly_cnt <= dly_cnt - 3'd1;
                    end
                end
                BUS_ACK: begin
                    if (bus.cpu_as_n) begin
                        dtack_n_q <= 1'b1;
                        state     <= BUS_IDLE;
                    end
                end
                default: begin
                    dtack_n_q <= 1'b1;
                    state     <= BUS_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: set only when an event is really lost (full, no pop
    // freeing a slot, and not swallowed by a flush); a new loss beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !fifo_pop && !flush) begin
            overflow <= 1'b1;
        end else if (ctrl_wr && bus.cpu_wdata[KBD_CTRL_CLR_OVF]) begin
            overflow <= 1'b0;
        end
    end

    // Interrupt enable and the registered level request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= bus.cpu_wdata[KBD_CTRL_IRQ_EN];
            end
            irq_q <= irq_en & ~fifo_empty;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.dtack_n = dtack_n_q;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_kbd_fifo_regs.sv
// -----------------------------------------------------------------------------
// tb_kbd_fifo_regs
// Directed self-checking bench for kbd_fifo_regs (FIFO_AW=3, DTACK_DLY=3).
// Honours KBD_TYPEMATIC_FILTER_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_kbd_fifo_regs;
    import kbd_pkg::*;

    logic        clk;
    logic        reset;
    logic [10:0] ps2_key;
    int          checks;
    int          failures;
    logic [15:0] rd;

    kbd_fifo_regs_if bus ();

    kbd_fifo_regs #(
        .FIFO_AW   (3),
        .DTACK_DLY (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2_key (ps2_key),
        .bus     (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait is ever left unbounded
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    // Present a new event on ps2_key right now (caller aligns to negedge)
    task automatic toggle_key(input logic pressed, input logic ext,
                              input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic send_key(input logic pressed, input logic ext,
                            input logic [7:0] code);
        @(negedge clk);
        toggle_key(pressed, ext, code);
        repeat (3) @(negedge clk);
    endtask

    // Start a bus cycle right now (caller aligns to negedge)
    task automatic bus_start(input logic rw, input logic [1:0] a,
                             input logic [15:0] wd);
        bus.cs        = 1'b1;
        bus.cpu_rw    = rw;
        bus.cpu_a     = a;
        bus.cpu_wdata = wd;
        bus.cpu_as_n  = 1'b0;
    endtask

    // Wait (bounded) for DTACK, capture data, release the strobe
    task automatic bus_finish(output logic [15:0] data);
        int n;
        n = 0;
        while (bus.dtack_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("dtack_seen", {15'b0, bus.dtack_n}, 16'h0000);
        data         = bus.dout;
        bus.cpu_as_n = 1'b1;
        bus.cs       = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic rw, input logic [1:0] a,
                                 input logic [15:0] wd, output logic [15:0] data);
        @(negedge clk);
        bus_start(rw, a, wd);
        bus_finish(data);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        ps2_key       = '0;
        bus.cs        = 1'b0;
        bus.cpu_as_n  = 1'b1;
        bus.cpu_rw    = 1'b1;
        bus.cpu_a     = 2'd0;
        bus.cpu_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_dout", bus.dout, 16'h0000);
        checkOutput("rst_dtack_n", {15'b0, bus.dtack_n}, 16'h0001);
        checkOutput("rst_irq", {15'b0, bus.irq}, 16'h0000);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("rst_status", rd, 16'h0000);

        // Three events, read back in order, then empty
        send_key(1'b1, 1'b0, 8'h1C);
        send_key(1'b1, 1'b0, 8'h32);
        send_key(1'b1, 1'b0, 8'h21);
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("three_status", rd, 16'h0003);
        applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
        checkOutput("three_data0", rd, 16'h821C);
        applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
        checkOutput("three_data1", rd, 16'h8232);
        applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
        checkOutput("three_data2", rd, 16'h8221);
        applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
        checkOutput("empty_data", rd, 16'h0000);

        // Ten events into an 8-deep FIFO: overflow, first 8 kept
        for (int i = 0; i < 10; i++) send_key(1'b1, 1'b0, 8'h40 + 8'(i));
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("ovf_status", rd, 16'h8008);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
            checkOutput("ovf_data", rd, 16'h8240 + 16'(i));
        end
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("ovf_sticky", rd, 16'h8000);
        applyStimulus(1'b0, KBD_REG_CTRL, 16'h0004, rd);
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("ovf_cleared", rd, 16'h0000);

        // Interrupt enable, raise on event, drop after pop
        applyStimulus(1'b0, KBD_REG_CTRL, 16'h0001, rd);
        applyStimulus(1'b1, KBD_REG_CTRL, 16'h0, rd);
        checkOutput("ctrl_read", rd, 16'h0001);
        @(negedge clk);
        toggle_key(1'b1, 1'b0, 8'h5A);
        @(negedge clk);
        checkOutput("irq_early", {15'b0, bus.irq}, 16'h0000);
        repeat (2) @(negedge clk);
        checkOutput("irq_rise", {15'b0, bus.irq}, 16'h0001);
        @(negedge clk);
        bus_start(1'b1, KBD_REG_DATA, 16'h0);
        repeat (2) @(negedge clk);
        checkOutput("irq_fall", {15'b0, bus.irq}, 16'h0000);
        bus_finish(rd);
        checkOutput("irq_data", rd, 16'h825A);

        // Push and pop in the same cycle with one entry held
        send_key(1'b1, 1'b0, 8'h11);
        @(negedge clk);
        toggle_key(1'b1, 1'b0, 8'h22);
        @(negedge clk);
        bus_start(1'b1, KBD_REG_DATA, 16'h0);
        bus_finish(rd);
        checkOutput("pp_old_head", rd, 16'h8211);
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("pp_count", rd, 16'h0001);
        applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
        checkOutput("pp_new_entry", rd, 16'h8222);

        // Full FIFO with same-cycle pop and push: accepted, no overflow
        for (int i = 0; i < 8; i++) send_key(1'b1, 1'b0, 8'h60 + 8'(i));
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("full_status", rd, 16'h0008);
        @(negedge clk);
        toggle_key(1'b1, 1'b0, 8'h68);
        @(negedge clk);
        bus_start(1'b1, KBD_REG_DATA, 16'h0);
        bus_finish(rd);
        checkOutput("full_pp_head", rd, 16'h8260);
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("full_pp_status", rd, 16'h0008);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
            checkOutput("full_pp_data", rd, 16'h8260 + 16'(i));
        end

        // Flush coinciding with a push discards both
        send_key(1'b1, 1'b0, 8'h70);
        @(negedge clk);
        toggle_key(1'b1, 1'b0, 8'h71);
        @(negedge clk);
        bus_start(1'b0, KBD_REG_CTRL, 16'h0002);
        bus_finish(rd);
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("flush_status", rd, 16'h0000);

        // DTACK timing with the strobe held for 10 clocks
        @(negedge clk);
        bus_start(1'b1, KBD_REG_STATUS, 16'h0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checkOutput("dtack_timing", {15'b0, bus.dtack_n},
                        (i >= 4) ? 16'h0000 : 16'h0001);
        end
        bus.cpu_as_n = 1'b1;
        bus.cs       = 1'b0;
        @(negedge clk);
        checkOutput("dtack_release", {15'b0, bus.dtack_n}, 16'h0001);
        @(negedge clk);

        // Reset pulse in the middle of an acknowledged access
        send_key(1'b1, 1'b0, 8'h72);
        @(negedge clk);
        bus_start(1'b1, KBD_REG_STATUS, 16'h0);
        repeat (5) @(negedge clk);
        checkOutput("pre_rst_dtack", {15'b0, bus.dtack_n}, 16'h0000);
        checkOutput("pre_rst_dout", bus.dout, 16'h0001);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_dtack", {15'b0, bus.dtack_n}, 16'h0001);
        checkOutput("mid_rst_dout", bus.dout, 16'h0000);
        bus.cpu_as_n = 1'b1;
        bus.cs       = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("post_rst_status", rd, 16'h0000);

        // Auto-repeat makes followed by a break
        for (int i = 0; i < 5; i++) send_key(1'b1, 1'b0, 8'h1C);
        send_key(1'b0, 1'b0, 8'h1C);
`ifdef KBD_TYPEMATIC_FILTER_EN
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("typ_status", rd, 16'h0002);
        applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
        checkOutput("typ_make", rd, 16'h821C);
`else
        applyStimulus(1'b1, KBD_REG_STATUS, 16'h0, rd);
        checkOutput("typ_status", rd, 16'h0006);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
            checkOutput("typ_make", rd, 16'h821C);
        end
`endif
        applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
        checkOutput("typ_break", rd, 16'h801C);
        applyStimulus(1'b1, KBD_REG_DATA, 16'h0, rd);
        checkOutput("typ_empty", rd, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
